hc165_shift_tx: RTL and testbench
=================================

HC165_SHIFT_TX -- requirements
Module: hc165_shift_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of data bits per frame, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = transmit Data[WIDTH-1] first, 0 = transmit Data[0] first.
REQ-003 SHALL have port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  request to send Data; sampled only in IDLE.
REQ-006 SHALL have port Data  input  WIDTH  parallel word, captured on accepted Start.
REQ-007 SHALL have port Tick  input  1  bit-rate enable; one bit period ends per Clk edge with Tick=1.
REQ-008 SHALL have port Q  output  1  registered serial data line.
REQ-009 SHALL have port Qn  output  1  registered complement of Q.
REQ-010 SHALL have port Frame  output  1  high while data or parity bits are on Q.
REQ-011 SHALL have port Busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port Done  output  1  one-Clk pulse at end of frame.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (macro-dependent), DONE.
REQ-014 IDLE: Q=0, Frame=0, Busy=0; Start=1 at edge n SHALL capture Data into shift register, clear bit counter, enter SHIFT.
REQ-015 At edge n+1 (Start accepted at edge n), Q SHALL equal the first bit, with Frame=1 and Busy=1 (one-cycle latency).
REQ-016 SHIFT: each Tick=1 edge SHALL advance the shift register one bit toward the output and increment the counter; Tick=0 SHALL hold Q and all state.
REQ-017 After the WIDTH-th Tick in SHIFT, SHALL enter PARITY if compiled in, else DONE.
REQ-018 DONE: SHALL last exactly one Clk; Done=1, Busy=0, Frame=0, Q=0; then IDLE unconditionally.
REQ-019 Start SHALL be ignored in SHIFT, PARITY and DONE; Data changes after capture SHALL not affect the frame.
REQ-020 Tick in IDLE or DONE SHALL be ignored; Start and Tick together in IDLE SHALL accept Start only (Tick not counted).
REQ-021 Qn SHALL equal ~Q at all times, including during and after reset.
REQ-022 Bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within a frame.
REQ-023 Minimum Start-to-Start spacing SHALL be WIDTH ticks (+1 with parity) plus 2 Clk.

Reset
REQ-024 Reset=1 SHALL immediately force IDLE, Q=0, Qn=1, Frame=0, Busy=0, Done=0, shift register and counter 0, without waiting for Clk.
REQ-025 Reset mid-frame SHALL abort the frame with no Done pulse; Start is honoured on the first Clk edge after Reset falls.

Configuration
REQ-026 With HC165_TX_PARITY_EN defined: after the last data bit, PARITY state SHALL drive Q = even parity (XOR) of the captured word for one Tick period, Frame=1, then DONE.
REQ-027 Without HC165_TX_PARITY_EN: PARITY state and its logic SHALL be absent; SHIFT goes directly to DONE.

Verification
REQ-028 Reset pulse mid-idle and mid-frame -> Q=0, Qn=1, Busy=0, Done=0 asynchronously; no Done afterwards.
REQ-029 WIDTH=8, MSB_FIRST=1, Data=0xA5, Start at edge 0, Tick=1 always, no parity -> Q = 1,0,1,0,0,1,0,1 on cycles 1..8; Done=1 on cycle 9 only; Busy=0 from cycle 9.
REQ-030 Same with MSB_FIRST=0 -> Q = 1,0,1,0,0,1,0,1 reversed from LSB: 1,0,1,0,0,1,0,1 for 0xA5; Data=0x01 -> Q = 1,0,0,0,0,0,0,0.
REQ-031 Parity enabled, Data=0x07 -> ninth bit Q=1; Data=0xA5 -> ninth bit Q=0; Done on cycle 10 with Tick=1 always.
REQ-032 Tick high one cycle in four, Data=0xF0 -> each bit held 4 Clk; Start=1 with Data=0x0F during the frame -> ignored, Q still transmits 0xF0.
REQ-033 Start and Tick both high in IDLE, Data=0x80 -> Q=1 held until next Tick; frame lasts 8 further Ticks.

Source files
------------

// File: rtl/hc165_shift_tx.sv
// Parallel-in / serial-out frame transmitter in the style of a 74HC165, paced by a bit-rate Tick.
// Optional even-parity bit after the data is compiled in with HC165_TX_PARITY_EN.
module hc165_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  input  logic             Tick,
  output logic             Q,
  output logic             Qn,
  output logic             Frame,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
`ifdef HC165_TX_PARITY_EN
    S_PARITY = 2'd2,
`endif
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             qn_q, qn_d;
  logic             frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             out_bit;
`ifdef HC165_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Handshake: Start is a level request sampled only in IDLE; there is no ready,
  // Busy/Frame/Done report frame progress one Clk after the state they describe.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
`ifdef HC165_TX_PARITY_EN
    par_d   = par_q;
`endif
    out_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          sr_d    = Data;
          cnt_d   = '0;
`ifdef HC165_TX_PARITY_EN
          par_d   = ^Data;
`endif
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (Tick) begin
          sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef HC165_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef HC165_TX_PARITY_EN
      S_PARITY: begin
        if (Tick) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line outputs are registered views of the current state, hence the one-Clk latency.
  always_comb begin
    q_d     = 1'b0;
    frame_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_SHIFT: begin
        q_d     = out_bit;
        frame_d = 1'b1;
        busy_d  = 1'b1;
      end
`ifdef HC165_TX_PARITY_EN
      S_PARITY: begin
        q_d     = par_q;
        frame_d = 1'b1;
        busy_d  = 1'b1;
      end
`endif
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        q_d = 1'b0;
      end
    endcase
    qn_d = ~q_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      qn_q    <= 1'b1;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HC165_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef HC165_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Q         = q_q;
  assign Qn        = qn_q;
  assign Frame     = frame_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hc165_shift_tx.sv
// Directed bench for hc165_shift_tx: MSB-first and LSB-first instances share all inputs.
module tb_hc165_shift_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] data = 8'h00;

  logic q_m, qn_m, frame_m, busy_m, done_m;
  logic q_l, qn_l, frame_l, busy_l, done_l;
  logic [1:0] st_m, st_l;

  int checks = 0;
  int failures = 0;

  hc165_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .Clk(clk), .Reset(rst), .Start(start), .Data(data), .Tick(tick),
    .Q(q_m), .Qn(qn_m), .Frame(frame_m), .Busy(busy_m), .Done(done_m),
    .dbg_state(st_m)
  );

  hc165_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .Clk(clk), .Reset(rst), .Start(start), .Data(data), .Tick(tick),
    .Q(q_l), .Qn(qn_l), .Frame(frame_l), .Busy(busy_l), .Done(done_l),
    .dbg_state(st_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         lsb;
    int         div;
    bit         start_tick;
    bit         disturb;
    logic [7:0] seq;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic qs, qns, fs, bs, ds;
    data  = v.data;
    start = 1'b1;
    tick  = v.start_tick;
    step();
    start = v.disturb;
    tick  = 1'b0;
    if (v.disturb) data = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < v.div; c++) begin
        tick = (c == v.div - 1);
        step();
        qs  = v.lsb ? q_l : q_m;
        qns = v.lsb ? qn_l : qn_m;
        fs  = v.lsb ? frame_l : frame_m;
        bs  = v.lsb ? busy_l : busy_m;
        chk({v.name, "_q"}, {15'd0, qs}, {15'd0, v.seq[7-i]});
        chk({v.name, "_qn"}, {15'd0, qns}, {15'd0, ~v.seq[7-i]});
        if (c == 0) chk({v.name, "_frame_busy"}, {14'd0, fs, bs}, 16'd3);
      end
    end
`ifdef HC165_TX_PARITY_EN
    for (int c = 0; c < v.div; c++) begin
      tick = (c == v.div - 1);
      step();
      qs = v.lsb ? q_l : q_m;
      fs = v.lsb ? frame_l : frame_m;
      chk({v.name, "_parity"}, {15'd0, qs}, {15'd0, v.par});
      chk({v.name, "_parity_frame"}, {15'd0, fs}, 16'd1);
    end
`endif
    start = 1'b0;
    tick  = 1'b0;
    step();
    qs  = v.lsb ? q_l : q_m;
    qns = v.lsb ? qn_l : qn_m;
    fs  = v.lsb ? frame_l : frame_m;
    bs  = v.lsb ? busy_l : busy_m;
    ds  = v.lsb ? done_l : done_m;
    chk({v.name, "_done_cycle"}, {11'd0, ds, bs, fs, qs, qns}, 16'h0011);
    step();
    ds = v.lsb ? done_l : done_m;
    chk({v.name, "_done_single"}, {15'd0, ds}, 16'd0);
  endtask

  initial begin
    bit saw_done;

    vecs[0] = '{"a5_msb",      8'hA5, 1'b0, 1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{"a5_lsb",      8'hA5, 1'b1, 1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{"01_lsb",      8'h01, 1'b1, 1, 1'b0, 1'b0, 8'h80, 1'b1};
    vecs[3] = '{"f0_div4_dist", 8'hF0, 1'b0, 4, 1'b0, 1'b1, 8'hF0, 1'b0};
    vecs[4] = '{"80_starttick", 8'h80, 1'b0, 3, 1'b1, 1'b0, 8'h80, 1'b1};
    vecs[5] = '{"07_msb",      8'h07, 1'b0, 1, 1'b0, 1'b0, 8'h07, 1'b1};
    vecs[6] = '{"12_lsb_div2", 8'h12, 1'b1, 2, 1'b0, 1'b0, 8'h48, 1'b0};

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_async_m", {11'd0, q_m, qn_m, frame_m, busy_m, done_m}, 16'h0008);
    chk("reset_async_l", {11'd0, q_l, qn_l, frame_l, busy_l, done_l}, 16'h0008);
    step();
    step();
    rst = 1'b0;

    // Tick alone in IDLE must not start anything.
    tick = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_tick_ignored", {13'd0, q_m, busy_m, done_m}, 16'd0);
    end
    tick = 1'b0;
    step();

    for (int n = 0; n < 7; n++) run_vec(vecs[n]);

    // Reset pulse while idle, released off the clock edge.
    #2 rst = 1'b1;
    #1;
    chk("reset_idle", {11'd0, q_m, qn_m, frame_m, busy_m, done_m}, 16'h0008);
    step();
    rst = 1'b0;
    step();

    // Reset mid-frame while Q is high: immediate clear, then no Done.
    data  = 8'hA5;
    start = 1'b1;
    tick  = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("pre_reset_q_high", {15'd0, q_m}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset_midframe_m", {11'd0, q_m, qn_m, frame_m, busy_m, done_m}, 16'h0008);
    chk("reset_midframe_l", {11'd0, q_l, qn_l, frame_l, busy_l, done_l}, 16'h0008);
    step();
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (done_m || done_l || busy_m) saw_done = 1'b1;
    end
    chk("no_done_after_reset", {15'd0, saw_done}, 16'd0);

    // Start present as reset falls is accepted on the first edge.
    #2 rst = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b1;
    data  = 8'hA5;
    tick  = 1'b0;
    step();
    start = 1'b0;
    step();
    chk("start_after_reset", {13'd0, q_m, busy_m, frame_m}, 16'h0007);
    tick = 1'b1;
    for (int k = 0; k < 12; k++) step();
    tick = 1'b0;
    chk("post_frame_idle", {13'd0, q_m, qn_m, busy_m}, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
